// File: rtl/audio_pkg.sv
// Shared types and constants for the variable-speed playback path.
// Mode decode and the 1/N reciprocal table live here so the reader and calculator agree.
package audio_pkg;

  localparam int unsigned AW_DEF = 20;
  localparam int unsigned DW_DEF = 16;

  // Q12 fixed-point reciprocal of the speed ratio.
  localparam int unsigned RecipFrac = 12;

  typedef enum logic [2:0] {
    StIdle,
    StFetch0,
    StFetch1,
    StWait,
    StCalc
  } state_e;

  typedef struct packed {
    logic       fast;
    logic       slow;
    logic       interp;
    logic [2:0] n_m1;
  } mode_t;

  function automatic logic [12:0] recip(input logic [2:0] n_m1);
    logic [12:0] r;
    case (n_m1)
      3'd0: r = 13'd4096;
      3'd1: r = 13'd2048;
      3'd2: r = 13'd1365;
      3'd3: r = 13'd1024;
      3'd4: r = 13'd819;
      3'd5: r = 13'd683;
      3'd6: r = 13'd585;
      3'd7: r = 13'd512;
      default: r = 13'd4096;
    endcase
    return r;
  endfunction

  // Normal overrides slow; interpolation only matters in slow mode.
  function automatic mode_t decode_mode(input logic       normal,
                                        input logic       slow,
                                        input logic       interp,
                                        input logic [2:0] ratio_m1);
    mode_t m;
    m.slow   = ~normal & slow;
    m.fast   = ~normal & ~slow;
    m.interp = ~normal & slow & interp;
    m.n_m1   = ratio_m1;
    return m;
  endfunction

endpackage

// File: rtl/audio_interp_calc.sv
// Combinational linear interpolation between two samples at phase k/N,
// floored to the sample grid and saturated to the sample range.
module audio_interp_calc
  import audio_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic signed [DW-1:0] s0_i,
  input  logic signed [DW-1:0] s1_i,
  input  logic        [2:0]    k_i,
  input  logic        [2:0]    n_m1_i,
  output logic signed [DW-1:0] sample_o
);

  localparam logic signed [32:0] SatMax = (33'sd1 <<< (DW - 1)) - 33'sd1;
  localparam logic signed [32:0] SatMin = -(33'sd1 <<< (DW - 1));

  logic signed [DW:0]   diff;
  logic        [15:0]   kw;
  logic signed [31:0]   diff_ext;
  logic signed [31:0]   weight;
  logic signed [31:0]   prod;
  logic signed [31:0]   delta;
  logic signed [32:0]   sum;

  always_comb begin
    diff     = {s1_i[DW-1], s1_i} - {s0_i[DW-1], s0_i};
    kw       = 16'(k_i) * 16'(recip(n_m1_i));
    diff_ext = {{(31 - DW){diff[DW]}}, diff};
    weight   = {16'b0, kw};
    prod     = diff_ext * weight;
    delta    = prod >>> RecipFrac;
    sum      = {{(33 - DW){s0_i[DW-1]}}, s0_i} + {delta[31], delta};
    if (sum > SatMax) begin
      sample_o = SatMax[DW-1:0];
    end else if (sum < SatMin) begin
      sample_o = SatMin[DW-1:0];
    end else begin
      sample_o = sum[DW-1:0];
    end
  end

endmodule

// File: rtl/audio_rate_player.sv
// Playback reader: fetches recorded samples from SRAM and emits one DAC sample per request,
// skipping (fast), passing through (normal) or repeating/interpolating (slow).
module audio_rate_player
  import audio_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          CLK50,
  input  logic          RST,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          isNormalSpeed,
  input  logic          isSlow,
  input  logic          interp,
  input  logic [2:0]    ratio_m1,
  input  logic [AW-1:0] end_addr,
  input  logic          sample_req,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_data,
  input  logic          sram_valid,
  output logic [DW-1:0] dac_sample,
  output logic          sample_valid,
  output logic          playing,
  output logic          done
);

  localparam logic [AW:0] One = (AW + 1)'(1);

  state_e             state_q;
  mode_t              mode_q;
  mode_t              new_mode;
  logic [AW-1:0]      addr_q;
  logic [2:0]         k_q;
  logic signed [DW-1:0] s0_q;
  logic signed [DW-1:0] s1_q;
  logic               sram_rd_q;
  logic [AW-1:0]      sram_addr_q;
  logic [DW-1:0]      dac_q;
  logic               valid_q;
  logic               playing_q;
  logic               done_q;
  logic               under_q;

  logic signed [DW-1:0] interp_out;
  logic [DW-1:0]      calc_out;
  logic [AW:0]        ratio_ext;
  logic [AW:0]        end_ext;
  logic [AW:0]        addr_next;
  logic [AW:0]        addr_p1;
  logic               next_over;
  logic               p1_over;
  logic               wrap;
  logic               advance;
  logic               fetching;

  audio_interp_calc #(
    .DW (DW)
  ) u_interp (
    .s0_i     (s0_q),
    .s1_i     (s1_q),
    .k_i      (k_q),
    .n_m1_i   (mode_q.n_m1),
    .sample_o (interp_out)
  );

  assign new_mode  = decode_mode(isNormalSpeed, isSlow, interp, ratio_m1);
  assign ratio_ext = {{(AW - 2){1'b0}}, mode_q.n_m1};
  assign end_ext   = {1'b0, end_addr};
  assign addr_next = {1'b0, addr_q} + (mode_q.fast ? ratio_ext + One : One);
  assign addr_p1   = {1'b0, addr_q} + One;
  assign next_over = addr_next > end_ext;
  assign p1_over   = addr_p1 > end_ext;
  assign wrap      = (k_q == mode_q.n_m1);
  // Slow mode only moves to the next recorded sample once all N phases have played.
  assign advance   = ~mode_q.slow | wrap;
  assign calc_out  = mode_q.interp ? interp_out : s0_q;
  assign fetching  = (state_q == StFetch0) || (state_q == StFetch1);

  always_ff @(posedge CLK50 or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      addr_q      <= '0;
      k_q         <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      sram_rd_q   <= 1'b0;
      sram_addr_q <= '0;
      dac_q       <= '0;
      valid_q     <= 1'b0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      valid_q <= under_q;
      done_q  <= 1'b0;
      under_q <= 1'b0;
      if (stop) begin
        state_q   <= StIdle;
        sram_rd_q <= 1'b0;
        playing_q <= 1'b0;
        valid_q   <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              addr_q    <= '0;
              k_q       <= '0;
              mode_q    <= new_mode;
              playing_q <= 1'b1;
              state_q   <= StFetch0;
            end
          end
          StFetch0: begin
            if (!sram_rd_q) begin
              sram_rd_q   <= 1'b1;
              sram_addr_q <= addr_q;
            end else if (sram_valid) begin
              sram_rd_q <= 1'b0;
              s0_q      <= sram_data;
              state_q   <= mode_q.interp ? StFetch1 : StWait;
            end
          end
          StFetch1: begin
            if (!sram_rd_q) begin
              // Past the recording end the ramp flattens onto the last sample.
              if (p1_over) begin
                s1_q    <= s0_q;
                state_q <= StWait;
              end else begin
                sram_rd_q   <= 1'b1;
                sram_addr_q <= addr_p1[AW-1:0];
              end
            end else if (sram_valid) begin
              sram_rd_q <= 1'b0;
              s1_q      <= sram_data;
              state_q   <= StWait;
            end
          end
          StWait: begin
            if (sample_req && !pause) begin
              state_q <= StCalc;
            end
          end
          StCalc: begin
            dac_q   <= calc_out;
            valid_q <= 1'b1;
            if (!advance) begin
              k_q     <= k_q + 3'd1;
              state_q <= StWait;
            end else begin
              k_q    <= '0;
              mode_q <= new_mode;
              if (next_over) begin
                done_q    <= 1'b1;
                playing_q <= 1'b0;
                state_q   <= StIdle;
              end else begin
                addr_q <= addr_next[AW-1:0];
                if (mode_q.interp) begin
                  s0_q    <= s1_q;
                  state_q <= new_mode.interp ? StFetch1 : StWait;
                end else begin
                  state_q <= StFetch0;
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
        // A request landing mid-refetch replays the previous sample.
        if (sample_req && !pause && fetching) begin
          under_q <= 1'b1;
        end
      end
    end
  end

  assign sram_rd      = sram_rd_q;
  assign sram_addr    = sram_addr_q;
  assign dac_sample   = dac_q;
  assign sample_valid = valid_q;
  assign playing      = playing_q;
  assign done         = done_q;

endmodule

// File: tb/tb_audio_rate_player.sv
// Directed bench for audio_rate_player: a vector table over the speed modes plus
// hand-written pause, underrun, stop and reset-during-read sequences.
module tb_audio_rate_player;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          CLK50 = 1'b0;
  logic          RST;
  logic          start, stop, pause, isNormalSpeed, isSlow, interp;
  logic [2:0]    ratio_m1;
  logic [AW-1:0] end_addr;
  logic          sample_req;
  logic          sram_rd;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data = '0;
  logic          sram_valid = 1'b0;
  logic [DW-1:0] dac_sample;
  logic          sample_valid;
  logic          playing;
  logic          done;

  audio_rate_player #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .CLK50         (CLK50),
    .RST           (RST),
    .start         (start),
    .stop          (stop),
    .pause         (pause),
    .isNormalSpeed (isNormalSpeed),
    .isSlow        (isSlow),
    .interp        (interp),
    .ratio_m1      (ratio_m1),
    .end_addr      (end_addr),
    .sample_req    (sample_req),
    .sram_rd       (sram_rd),
    .sram_addr     (sram_addr),
    .sram_data     (sram_data),
    .sram_valid    (sram_valid),
    .dac_sample    (dac_sample),
    .sample_valid  (sample_valid),
    .playing       (playing),
    .done          (done)
  );

  always #5 CLK50 = ~CLK50;

  // SRAM model: fixed latency, keeps answering even if the request was withdrawn.
  logic [DW-1:0] mem [0:31];
  int            mem_lat = 2;
  int            mem_cnt = 0;
  bit            mem_busy = 1'b0;
  logic [AW-1:0] mem_a = '0;

  always @(negedge CLK50) begin
    if (sram_valid) sram_valid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        sram_valid = 1'b1;
        sram_data  = mem[mem_a[4:0]];
        mem_busy   = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (sram_rd) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat;
      mem_a    = sram_addr;
    end
  end

  typedef struct packed {
    bit       normal;
    bit       slow;
    bit       intp;
    bit [2:0] r;
    int       end_a;
    int       base;
    int       stride;
    int       nreq;
    int       done_at;
    int       e0;
    int       e1;
    int       e2;
    int       e3;
    int       e4;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_of(input vec_t v, input int i);
    case (i)
      0: return v.e0;
      1: return v.e1;
      2: return v.e2;
      3: return v.e3;
      default: return v.e4;
    endcase
  endfunction

  task automatic tick();
    @(negedge CLK50);
  endtask

  task automatic pulse_start();
    @(negedge CLK50);
    start = 1'b1;
    @(negedge CLK50);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge CLK50);
    stop = 1'b1;
    @(negedge CLK50);
    stop = 1'b0;
  endtask

  task automatic load_mem(input int base, input int stride);
    for (int i = 0; i < 32; i++) mem[i] = 16'(base + i * stride);
  endtask

  task automatic do_req(output bit got, output int lat, output int val,
                        output bit dn, output bit pl);
    got = 1'b0;
    lat = 0;
    val = 0;
    dn  = 1'b0;
    pl  = 1'b0;
    @(negedge CLK50);
    sample_req = 1'b1;
    @(negedge CLK50);
    sample_req = 1'b0;
    while (!got && lat < 100) begin
      @(negedge CLK50);
      lat++;
      if (sample_valid) begin
        got = 1'b1;
        val = $signed(dac_sample);
        dn  = done;
        pl  = playing;
      end
    end
  endtask

  initial begin
    vec_t v;
    bit   got, dn, pl;
    int   lat, val, seen;

    vecs[0] = '{1, 0, 0, 3'd0, 15, 0, 1, 4, 0, 0, 1, 2, 3, 0};
    vecs[1] = '{0, 0, 0, 3'd2, 15, 0, 1, 4, 0, 0, 3, 6, 9, 0};
    vecs[2] = '{0, 0, 0, 3'd2, 7, 0, 1, 3, 3, 0, 3, 6, 0, 0};
    vecs[3] = '{0, 1, 0, 3'd1, 1, 100, 100, 4, 4, 100, 100, 200, 200, 0};
    vecs[4] = '{0, 1, 1, 3'd2, 1, 0, 300, 4, 0, 0, 99, 199, 300, 0};
    vecs[5] = '{0, 1, 1, 3'd2, 1, 32767, -65535, 4, 0, 32767, 10927, -10913, -32768, 0};
    vecs[6] = '{1, 1, 1, 3'd3, 15, 0, 1, 4, 0, 0, 1, 2, 3, 0};
    vecs[7] = '{0, 0, 0, 3'd7, 20, 0, 1, 3, 3, 0, 8, 16, 0, 0};
    vecs[8] = '{0, 1, 0, 3'd0, 15, 5, 1, 4, 0, 5, 6, 7, 8, 0};
    vecs[9] = '{0, 1, 1, 3'd3, 3, 0, 400, 5, 0, 0, 100, 200, 300, 400};

    RST = 1'b1;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    isNormalSpeed = 1'b1; isSlow = 1'b0; interp = 1'b0;
    ratio_m1 = '0; end_addr = '0; sample_req = 1'b0;
    load_mem(0, 1);
    tick(); tick();
    check("reset.sram_rd", sram_rd, 0);
    check("reset.sram_addr", sram_addr, 0);
    check("reset.dac_sample", dac_sample, 0);
    check("reset.sample_valid", sample_valid, 0);
    check("reset.playing", playing, 0);
    check("reset.done", done, 0);
    RST = 1'b0;
    tick();

    for (int vi = 0; vi < NV; vi++) begin
      v = vecs[vi];
      pulse_stop();
      repeat (12) tick();
      load_mem(v.base, v.stride);
      isNormalSpeed = v.normal;
      isSlow        = v.slow;
      interp        = v.intp;
      ratio_m1      = v.r;
      end_addr      = AW'(v.end_a);
      pulse_start();
      check($sformatf("v%0d.playing", vi), playing, 1);
      repeat (30) tick();
      for (int r = 0; r < v.nreq; r++) begin
        do_req(got, lat, val, dn, pl);
        check($sformatf("v%0d.r%0d.valid", vi, r), got, 1);
        check($sformatf("v%0d.r%0d.latency", vi, r), lat, 1);
        check($sformatf("v%0d.r%0d.sample", vi, r), val, exp_of(v, r));
        check($sformatf("v%0d.r%0d.done", vi, r), dn, (r + 1 == v.done_at) ? 1 : 0);
        check($sformatf("v%0d.r%0d.playing", vi, r), pl, (r + 1 == v.done_at) ? 0 : 1);
        repeat (30) tick();
      end
    end

    // Pause mid-play, then an underrun right after a sample.
    pulse_stop();
    repeat (12) tick();
    mem_lat = 5;
    load_mem(0, 1);
    isNormalSpeed = 1'b1; isSlow = 1'b0; interp = 1'b0; ratio_m1 = '0; end_addr = 15;
    pulse_start();
    repeat (30) tick();
    for (int r = 0; r < 2; r++) begin
      do_req(got, lat, val, dn, pl);
      check($sformatf("pause.pre%0d", r), val, r);
      repeat (30) tick();
    end
    pause = 1'b1;
    seen = 0;
    for (int r = 0; r < 3; r++) begin
      @(negedge CLK50);
      sample_req = 1'b1;
      @(negedge CLK50);
      sample_req = 1'b0;
      repeat (20) begin
        @(negedge CLK50);
        if (sample_valid) seen++;
      end
    end
    check("pause.no_valid", seen, 0);
    check("pause.hold", $signed(dac_sample), 1);
    check("pause.playing", playing, 1);
    pause = 1'b0;
    do_req(got, lat, val, dn, pl);
    check("pause.resume", val, 2);
    repeat (30) tick();
    do_req(got, lat, val, dn, pl);
    check("under.pre", val, 3);
    do_req(got, lat, val, dn, pl);
    check("under.valid", got, 1);
    check("under.repeat", val, 3);
    repeat (30) tick();
    do_req(got, lat, val, dn, pl);
    check("under.next", val, 4);

    // start and stop together while idle: stop wins.
    pulse_stop();
    repeat (12) tick();
    @(negedge CLK50);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge CLK50);
    start = 1'b0;
    stop  = 1'b0;
    tick();
    check("startstop.playing", playing, 0);
    check("startstop.sram_rd", sram_rd, 0);

    // stop while a slow read is pending.
    load_mem(50, 1);
    pulse_start();
    tick();
    check("stop.rd_pending", sram_rd, 1);
    pulse_stop();
    check("stop.sram_rd", sram_rd, 0);
    check("stop.playing", playing, 0);
    seen = 0;
    repeat (12) begin
      @(negedge CLK50);
      if (done || sram_rd || sample_valid || playing) seen++;
    end
    check("stop.quiet", seen, 0);

    // RST while the refetch after a sample is outstanding.
    pulse_start();
    repeat (30) tick();
    do_req(got, lat, val, dn, pl);
    check("rst.pre_sample", val, 50);
    tick();
    check("rst.rd_pending", sram_rd, 1);
    #2 RST = 1'b1;
    #1;
    check("rst.async_rd", sram_rd, 0);
    check("rst.dac_cleared", dac_sample, 0);
    check("rst.playing", playing, 0);
    @(negedge CLK50);
    RST = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge CLK50);
      if (done || sram_rd || sample_valid || playing) seen++;
    end
    check("rst.quiet", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
